tdc_acq_ctrl: RTL and testbench

//  Sequencer for the tapped-delay-line TDC. Arms the delay-line capture, detects hits, waits for the

---
 rtl/tdc_acq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tdc_acq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_acq_ctrl.sv
// tdc_acq_ctrl: acquisition sequencer for the tapped-delay-line TDC.
// Arms the capture, turns hit edges into capture pulses, stores merged fine
// codes into an external 1-cycle BRAM and drains them in write order.
// Build option: define TDC_CTRL_TIMESTAMP_EN to prepend a free-running
// COARSE_W timestamp to every stored word.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | nothing in flight; accepts write enable or drain request
// ARMED      | delay line armed, waiting for a hit rising edge
// WAIT_MERGE | capture issued, waiting for encoder result (bounded)
// READ       | draining stored words to the readout side
module tdc_acq_ctrl #(
  parameter int DIG_OUT    = 9,
  parameter int COARSE_W   = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int MERGE_TO   = 8,
`ifdef TDC_CTRL_TIMESTAMP_EN
  localparam int W = COARSE_W + DIG_OUT
`else
  localparam int W = DIG_OUT
`endif
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iHit,
  input  logic                  startWriting,
  input  logic                  startReading,
  input  logic                  iClrErr,
  input  logic                  iMergeDone,
  input  logic [DIG_OUT-1:0]    iCode,
  output logic                  oArm,
  output logic                  oCapture,
  output logic                  oWrEn,
  output logic [DEPTH_LOG2-1:0] oWrAddr,
  output logic [W-1:0]          oWrData,
  output logic                  oRdEn,
  output logic [DEPTH_LOG2-1:0] oRdAddr,
  input  logic [W-1:0]          iRdData,
  output logic [W-1:0]          oData,
  output logic                  oDataValid,
  output logic                  led_WriteERR,
  output logic                  led_ReadERR
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int TW = $clog2(MERGE_TO + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);
  localparam logic [TW-1:0] TMO_LAST = TW'(MERGE_TO - 1);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_MERGE, READ} state_t;

  state_t                state;
  logic                  hit_q;
  logic                  hit_rise;
  logic                  accept_hit;
  logic                  timeout;
  logic                  wr_err_set;
  logic                  rd_err_set;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         rd_left;
  logic [TW-1:0]         timer;
  logic                  rd_pend;
  logic [W-1:0]          wr_word;

  // Event decode: hit edge, accepted capture, merge timeout and error set terms
  always_comb begin
    hit_rise   = iHit & ~hit_q;
    accept_hit = (state == ARMED) && startWriting && hit_rise && (count < DEPTH_C);
    timeout    = (state == WAIT_MERGE) && !iMergeDone && (timer == TMO_LAST);
    wr_err_set = timeout ||
                 ((state == ARMED) && startWriting && hit_rise && (count == DEPTH_C));
    rd_err_set = (state == IDLE) && !startWriting && startReading && (count == '0);
  end

`ifdef TDC_CTRL_TIMESTAMP_EN
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] ts;

  // Free-running coarse counter; its value is frozen on the accepted hit edge
  always_ff @(posedge iClk) begin
    if (iRst) begin
      coarse <= '0;
      ts     <= '0;
    end else begin
      coarse <= coarse + 1'b1;
      if (accept_hit) ts <= coarse;
    end
  end

  // Stored word: timestamp above the fine code
  always_comb wr_word = {ts, iCode};
`else
  // Coarse width only matters when timestamps are built in
  logic unused_coarse_w;
  assign unused_coarse_w = ^COARSE_W;

  // Stored word: fine code only
  always_comb wr_word = iCode;
`endif

  // Sequencer: state, pointers, registered strobes, read pipeline and sticky flags
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state        <= IDLE;
      hit_q        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_left      <= '0;
      timer        <= '0;
      rd_pend      <= 1'b0;
      oArm         <= 1'b0;
      oCapture     <= 1'b0;
      oWrEn        <= 1'b0;
      oWrAddr      <= '0;
      oWrData      <= '0;
      oRdEn        <= 1'b0;
      oRdAddr      <= '0;
      oData        <= '0;
      oDataValid   <= 1'b0;
      led_WriteERR <= 1'b0;
      led_ReadERR  <= 1'b0;
    end else begin
      hit_q      <= iHit;
      oCapture   <= 1'b0;
      oWrEn      <= 1'b0;
      oRdEn      <= 1'b0;
      rd_pend    <= oRdEn;
      oDataValid <= rd_pend;
      if (rd_pend) oData <= iRdData;

      if (wr_err_set)   led_WriteERR <= 1'b1;
      else if (iClrErr) led_WriteERR <= 1'b0;
      if (rd_err_set)   led_ReadERR  <= 1'b1;
      else if (iClrErr) led_ReadERR  <= 1'b0;

      case (state)
        IDLE: begin
          if (startWriting) begin
            state <= ARMED;
            oArm  <= 1'b1;
          end else if (startReading && (count != '0)) begin
            state   <= READ;
            rd_left <= count;
          end
        end
        ARMED: begin
          if (!startWriting) begin
            state <= IDLE;
            oArm  <= 1'b0;
          end else if (accept_hit) begin
            state    <= WAIT_MERGE;
            oArm     <= 1'b0;
            oCapture <= 1'b1;
            timer    <= '0;
          end
        end
        WAIT_MERGE: begin
          if (iMergeDone) begin
            oWrEn   <= 1'b1;
            oWrAddr <= wr_ptr;
            oWrData <= wr_word;
            wr_ptr  <= wr_ptr + 1'b1;
            count   <= count + 1'b1;
          end
          if (iMergeDone || timeout) begin
            state <= startWriting ? ARMED : IDLE;
            oArm  <= startWriting;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        READ: begin
          if (rd_left != '0) begin
            oRdEn   <= 1'b1;
            oRdAddr <= rd_ptr;
            rd_ptr  <= rd_ptr + 1'b1;
            rd_left <= rd_left - 1'b1;
          end else if (!oRdEn && !rd_pend) begin
            // last beat has left the output register
            count  <= '0;
            rd_ptr <= wr_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_acq_ctrl.sv
// Self-checking bench for tdc_acq_ctrl (default build, 9-bit words).
// Reference: a word queue capped at 16 entries plus two sticky flags.
module tb_tdc_acq_ctrl;

  logic       clk = 1'b0;
  logic       iRst, iHit, startWriting, startReading, iClrErr, iMergeDone;
  logic [8:0] iCode;
  logic       oArm, oCapture, oWrEn, oRdEn, oDataValid, led_WriteERR, led_ReadERR;
  logic [3:0] oWrAddr, oRdAddr;
  logic [8:0] oWrData, iRdData, oData;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] m_q[$];
  int         m_wr;
  bit         m_werr, m_rerr;

  logic [8:0] mem [16];

  tdc_acq_ctrl dut (
    .iClk(clk), .iRst(iRst), .iHit(iHit), .startWriting(startWriting),
    .startReading(startReading), .iClrErr(iClrErr), .iMergeDone(iMergeDone),
    .iCode(iCode), .oArm(oArm), .oCapture(oCapture), .oWrEn(oWrEn),
    .oWrAddr(oWrAddr), .oWrData(oWrData), .oRdEn(oRdEn), .oRdAddr(oRdAddr),
    .iRdData(iRdData), .oData(oData), .oDataValid(oDataValid),
    .led_WriteERR(led_WriteERR), .led_ReadERR(led_ReadERR)
  );

  always #5 clk = ~clk;

  // external 1-cycle BRAM
  always @(posedge clk) begin
    if (oWrEn) mem[oWrAddr] <= oWrData;
    if (oRdEn) iRdData <= mem[oRdAddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    iRst = 1'b1; iHit = 1'b0; startWriting = 1'b0; startReading = 1'b0;
    iClrErr = 1'b0; iMergeDone = 1'b0; iCode = '0;
    repeat (2) @(negedge clk);
    iRst = 1'b0;
    m_q.delete(); m_wr = 0; m_werr = 0; m_rerr = 0;
  endtask

  // One hit while armed. d = cycles after the capture cycle at which the merge
  // result arrives (0..7 accepted, >7 = never). spur = offset of an extra hit
  // during the merge wait (-1 = none).
  task automatic hit_merge(input logic [8:0] code, input int d, input int spur);
    bit full = (m_q.size() >= 16);
    bit saw_wr = 0;
    bit saw_cap = 0;
    @(negedge clk);
    iHit = 1'b1;
    @(negedge clk);
    iHit = 1'b0;
    chk("capture", oCapture, !full);
    if (full) begin
      m_werr = 1;
      chk("werr_full", led_WriteERR, 1);
      chk("arm_full", oArm, 1);
      return;
    end
    chk("arm_drop", oArm, 0);
    if (d <= 7) begin
      for (int i = 0; i < d; i++) begin
        if (i == spur) iHit = 1'b1;
        @(negedge clk);
        iHit = 1'b0;
        saw_wr |= oWrEn;
        saw_cap |= oCapture;
      end
      iCode = code; iMergeDone = 1'b1;
      @(negedge clk);
      iMergeDone = 1'b0; iCode = 9'($urandom);
      chk("early_wr", saw_wr, 0);
      chk("spur_cap", saw_cap, 0);
      chk("wr_en", oWrEn, 1);
      chk("wr_addr", oWrAddr, m_wr);
      chk("wr_data", oWrData, code);
      chk("arm_back", oArm, 1);
      chk("werr_hold", led_WriteERR, m_werr);
      m_q.push_back(code);
      m_wr = (m_wr + 1) % 16;
    end else begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        saw_wr |= oWrEn;
      end
      m_werr = 1;
      chk("tmo_nowr", saw_wr, 0);
      chk("tmo_werr", led_WriteERR, 1);
      chk("tmo_arm", oArm, 1);
    end
  endtask

  task automatic drain();
    logic [8:0] got[$];
    int nrd = 0;
    startWriting = 1'b0;
    @(negedge clk);
    startReading = 1'b1;
    @(negedge clk);
    startReading = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oRdEn) nrd++;
      if (oDataValid) got.push_back(oData);
      @(negedge clk);
    end
    if (m_q.size() == 0) m_rerr = 1;
    chk("rd_beats", got.size(), m_q.size());
    chk("rd_strobes", nrd, m_q.size());
    for (int i = 0; i < got.size() && i < m_q.size(); i++)
      chk("rd_data", got[i], m_q[i]);
    chk("rerr", led_ReadERR, m_rerr);
    chk("werr", led_WriteERR, m_werr);
    m_q.delete();
  endtask

  typedef struct {
    logic rst, sw, sr, clr;
    logic arm, werr, rerr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[3] = '{0, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0};

    do_reset();
    chk("rst_arm", oArm, 0);
    chk("rst_cap", oCapture, 0);
    chk("rst_wr", oWrEn, 0);
    chk("rst_rd", oRdEn, 0);
    chk("rst_dv", oDataValid, 0);
    chk("rst_flags", {led_WriteERR, led_ReadERR}, 0);

    // control-level vectors
    for (int i = 0; i < 9; i++) begin
      iRst = tbl[i].rst; startWriting = tbl[i].sw;
      startReading = tbl[i].sr; iClrErr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d_arm", i), oArm, tbl[i].arm);
      chk($sformatf("vec%0d_werr", i), led_WriteERR, tbl[i].werr);
      chk($sformatf("vec%0d_rerr", i), led_ReadERR, tbl[i].rerr);
      chk($sformatf("vec%0d_rd", i), oRdEn, 0);
    end

    // single write, merge 3 cycles after capture
    do_reset();
    startWriting = 1'b1;
    hit_merge(9'h05A, 3, -1);

    // two writes then drain
    do_reset();
    startWriting = 1'b1;
    hit_merge(9'h011, 2, -1);
    hit_merge(9'h022, 0, -1);
    drain();

    // empty drain, then clear
    drain();
    iClrErr = 1'b1;
    @(negedge clk);
    iClrErr = 1'b0; m_rerr = 0;
    chk("clr_rerr", led_ReadERR, 0);

    // fill to capacity, overflow, drain in order
    do_reset();
    startWriting = 1'b1;
    for (int i = 0; i < 17; i++) hit_merge(9'($urandom), i % 8, -1);
    drain();

    // merge timeout; last accepted merge offset; hit ignored while waiting
    do_reset();
    startWriting = 1'b1;
    hit_merge(9'h1FF, 99, -1);
    hit_merge(9'h0C3, 7, -1);
    hit_merge(9'h134, 5, 2);
    drain();

    // reset in the middle of a drain
    begin
      int beats = 0;
      int guard = 0;
      do_reset();
      startWriting = 1'b1;
      for (int i = 0; i < 5; i++) hit_merge(9'(i + 1), 1, -1);
      startWriting = 1'b0;
      @(negedge clk);
      startReading = 1'b1;
      @(negedge clk);
      startReading = 1'b0;
      while (beats < 2 && guard < 30) begin
        @(negedge clk);
        guard++;
        if (oDataValid) beats++;
      end
      chk("mid_beats", beats, 2);
      iRst = 1'b1;
      @(negedge clk);
      chk("mid_dv", oDataValid, 0);
      chk("mid_rd", oRdEn, 0);
      iRst = 1'b0;
      startReading = 1'b1;
      @(negedge clk);
      startReading = 1'b0;
      chk("mid_empty", led_ReadERR, 1);
    end

    // randomized sessions against the queue model
    for (int r = 0; r < 30; r++) begin
      int nh;
      do_reset();
      startWriting = 1'b1;
      nh = $urandom_range(0, 20);
      for (int h = 0; h < nh; h++) begin
        int d;
        int sp;
        d  = $urandom_range(0, 9);
        sp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
        hit_merge(9'($urandom), d, sp);
        if ($urandom_range(0, 7) == 0) begin
          iClrErr = 1'b1;
          @(negedge clk);
          iClrErr = 1'b0;
          m_werr = 0; m_rerr = 0;
          chk("rnd_clr", {led_WriteERR, led_ReadERR}, 0);
        end
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
